mips_main_control: RTL and testbench

- Multicycle MIPS main control FSM.
- Consumes the instruction opcode and produces every datapath control strobe, including the ALUOp and andi/ori/addi qualifiers that the ALU-control decoder turns into an ALU operation.
- Sits between the instruction register and the datapath; it is the producer end of the ALUOp/immediate-flag interface.

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/mips_main_control_if.sv | 29 ++
 rtl/mips_ctrl_decode.sv | 89 ++++++++
 rtl/mips_main_control.sv | 81 ++++++++
 tb/tb_mips_main_control.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// mux selects, FSM states and the bundled control-strobe struct.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       andi;
    logic       ori;
    logic       addi;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_main_control_if.sv
// Opcode/mem_ready inputs and every datapath strobe of the main control FSM.
interface mips_main_control_if;
  import mips_pkg::*;

  // mem_ready: memory raises it in the cycle its access completes; the FSM
  // holds its memory strobes steady and only advances on a cycle where it is 1.
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       andi, ori, addi;
  logic       illegal_op, instr_done;
  state_e     dbg_state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
           andi, ori, addi, illegal_op, instr_done, dbg_state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
           andi, ori, addi, illegal_op, instr_done, dbg_state
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Pure state-to-strobe decode; only FETCH/MEMWR look at mem_ready and only
// DECODE/IEXEC look at the (IR-held) opcode.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_rdy,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        // Unknown opcodes retire here as a NOP.
        if (!is_known_op(opcode)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_rdy;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_IMM;
        ctrl.addi      = (opcode == OP_ADDI);
        ctrl.andi      = (opcode == OP_ANDI);
        ctrl.ori       = (opcode == OP_ORI);
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM: state register and next-state logic;
// strobes come from mips_ctrl_decode.
module mips_main_control
  import mips_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mips_main_control_if.master        bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_rdy;

  assign mem_rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_REXEC;
          OP_BEQ:                    state_d = S_BEQ;
          OP_J:                      state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
          default:                   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      // Encodings 13..15 are never entered; fall back to a clean restart.
      default:  state_d = S_IDLE;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state   (state_q),
    .opcode  (bus.opcode),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.andi        = ctrl.andi;
  assign bus.ori         = ctrl.ori;
  assign bus.addi        = ctrl.addi;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: per-instruction expected strobe traces built
// from the instruction-level behaviour, compared cycle by cycle.
module tb_mips_main_control;
  import mips_pkg::*;

  localparam int W = 21;

  // Output word layout (MSB first): PCWrite PCWriteCond IorD MemRead MemWrite
  // IRWrite MemtoReg ALUSrcA RegWrite RegDst PCSource[2] ALUSrcB[2] ALUOp[2]
  // andi ori addi illegal_op instr_done
  localparam logic [W-1:0] B_PCW   = 21'h100000;
  localparam logic [W-1:0] B_PCWC  = 21'h080000;
  localparam logic [W-1:0] B_IORD  = 21'h040000;
  localparam logic [W-1:0] B_MRD   = 21'h020000;
  localparam logic [W-1:0] B_MWR   = 21'h010000;
  localparam logic [W-1:0] B_IRW   = 21'h008000;
  localparam logic [W-1:0] B_M2R   = 21'h004000;
  localparam logic [W-1:0] B_SRCA  = 21'h002000;
  localparam logic [W-1:0] B_RW    = 21'h001000;
  localparam logic [W-1:0] B_RDST  = 21'h000800;
  localparam logic [W-1:0] B_ANDI  = 21'h000010;
  localparam logic [W-1:0] B_ORI   = 21'h000008;
  localparam logic [W-1:0] B_ADDI  = 21'h000004;
  localparam logic [W-1:0] B_ILL   = 21'h000002;
  localparam logic [W-1:0] B_DONE  = 21'h000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_main_control_if bus ();

  mips_main_control #(.USE_MEM_READY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic [5:0]   op_q[$];
  string        tag_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] pcsrc(input logic [1:0] v);
    return {10'b0, v, 9'b0};
  endfunction
  function automatic logic [W-1:0] srcb(input logic [1:0] v);
    return {12'b0, v, 7'b0};
  endfunction
  function automatic logic [W-1:0] aluop(input logic [1:0] v);
    return {14'b0, v, 5'b0};
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
            bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.andi, bus.ori, bus.addi,
            bus.illegal_op, bus.instr_done};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100,
      6'b000010, 6'b001000, 6'b001100, 6'b001101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [W-1:0] e, input logic rdy, input logic [5:0] op,
                      input string tag);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
    tag_q.push_back(tag);
  endtask

  // Expected per-cycle strobes for one instruction. fs/ms are the number of
  // not-ready cycles in fetch and in the data access. Cycles where mem_ready
  // must not matter get a random mem_ready; fetch cycles get a random opcode.
  task automatic plan(input logic [5:0] op, input int fs, input int ms);
    logic r;
    for (int i = 0; i < fs; i++)
      push(B_MRD | srcb(2'b01), 1'b0, 6'($urandom), "fetch_stall");
    push(B_MRD | srcb(2'b01) | B_PCW | B_IRW, 1'b1, 6'($urandom), "fetch");
    r = 1'($urandom);
    if (!is_legal(op)) begin
      push(srcb(2'b11) | B_ILL | B_DONE, r, op, "decode_illegal");
      return;
    end
    push(srcb(2'b11), r, op, "decode");
    r = 1'($urandom);
    case (op)
      6'b100011: begin
        push(B_SRCA | srcb(2'b10), r, op, "lw_memadr");
        for (int i = 0; i < ms; i++) push(B_MRD | B_IORD, 1'b0, op, "lw_memrd_stall");
        push(B_MRD | B_IORD, 1'b1, op, "lw_memrd");
        push(B_RW | B_M2R | B_DONE, 1'($urandom), op, "lw_wb");
      end
      6'b101011: begin
        push(B_SRCA | srcb(2'b10), r, op, "sw_memadr");
        for (int i = 0; i < ms; i++) push(B_MWR | B_IORD, 1'b0, op, "sw_memwr_stall");
        push(B_MWR | B_IORD | B_DONE, 1'b1, op, "sw_memwr");
      end
      6'b000000: begin
        push(B_SRCA | aluop(2'b10), r, op, "r_exec");
        push(B_RW | B_RDST | B_DONE, 1'($urandom), op, "r_wb");
      end
      6'b000100: push(B_SRCA | aluop(2'b01) | B_PCWC | pcsrc(2'b01) | B_DONE, r, op, "beq");
      6'b000010: push(B_PCW | pcsrc(2'b10) | B_DONE, r, op, "jump");
      default: begin
        logic [W-1:0] flag;
        flag = (op == 6'b001000) ? B_ADDI : (op == 6'b001100) ? B_ANDI : B_ORI;
        push(B_SRCA | srcb(2'b10) | aluop(2'b11) | flag, r, op, "i_exec");
        push(B_RW | B_DONE, 1'($urandom), op, "i_wb");
      end
    endcase
  endtask

  task automatic run_cycles(input int n);
    logic [W-1:0] e;
    string t;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
      bus.mem_ready = rdy_q.pop_front();
      bus.opcode    = op_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clk);
      chk(t, 32'(obs_word()), 32'(e));
    end
  endtask

  task automatic flush();
    exp_q.delete();
    rdy_q.delete();
    op_q.delete();
    tag_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops [8];
    logic [5:0] op;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000010, 6'b001000, 6'b001100, 6'b001101};

    bus.opcode    = 6'b0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 32'(obs_word()), 32'd0);
      chk("reset_state", 32'(bus.dbg_state), 32'(S_IDLE));
    end
    rst_n = 1'b1;

    // Directed: lw, sw with stalls, immediates, beq, j, illegal.
    plan(6'b100011, 0, 0);
    plan(6'b101011, 3, 2);
    plan(6'b001100, 0, 0);
    plan(6'b001101, 0, 0);
    plan(6'b001000, 0, 0);
    plan(6'b000100, 0, 0);
    plan(6'b000010, 0, 0);
    plan(6'b111111, 0, 0);
    plan(6'b000000, 1, 0);
    run_cycles(1000);

    // Random instruction mix with random stalls.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      plan(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run_cycles(100000);

    // Reset asserted while a store is waiting in its write cycle.
    plan(6'b101011, 0, 3);
    run_cycles(4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", 32'(bus.MemWrite), 32'd0);
    chk("rst_midinstr_state", 32'(bus.dbg_state), 32'(S_IDLE));
    chk("rst_midinstr_outputs", 32'(obs_word()), 32'd0);
    flush();
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_outputs", 32'(obs_word()), 32'd0);
    end
    rst_n = 1'b1;
    plan(6'b000010, 0, 0);
    plan(6'b100011, 1, 1);
    run_cycles(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
